div_unit: RTL
=============

# div_unit

Multi-cycle 32-bit integer divider for DIV/DIVU. It sits between the execute stage and the HI/LO register file. Execute starts it and holds the pipeline until `ready_o`. The 64-bit result is then forwarded through MEM/WB to the HI/LO write port: remainder goes to HI, quotient to LO. It uses a radix-2 restoring algorithm: one quotient bit per cycle, 32 iterations, sign fix-up for signed operation.

## Interface
- No parameters; width fixed at 32 (`RegBus`).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset (`RstEnable` = 1).
- `signed_div_i` in 1: 1 = DIV (signed), 0 = DIVU.
- `opdata1_i` in 32: dividend.
- `opdata2_i` in 32: divisor.
- `start_i` in 1: request; held high by execute until it sees `ready_o`.
- `annul_i` in 1: cancel (branch/exception flush).
- `result_o` out 64: {remainder[63:32], quotient[31:0]}.
- `ready_o` out 1: `result_o` valid.

## Operation
- States are IDLE, BYZERO, ON and END. Reset forces IDLE, `result_o` = 0, `ready_o` = 0, counter = 0.
- **IDLE**
  - If `start_i` = 1 and `annul_i` = 0, latch the operands.
  - If the divisor is 0, go to BYZERO.
  - Otherwise go to ON. For signed operation, latch |dividend| and |divisor| (two's-complement negate when bit 31 = 1) and latch the original signs. Counter = 0.
  - Otherwise stay in IDLE, with `ready_o` = 0 and `result_o` = 0.
- **BYZERO**: load the result with 0 and go to END.
- **ON**, each cycle with `annul_i` = 0:
  - Working register is 65 bits, {partial remainder[64:32], dividend shift[31:0]}.
  - Trial = remainder[63:31] − {1'b0, divisor}, 33 bits.
  - If trial ≥ 0: shift left, insert quotient bit 1, upper = trial[31:0].
  - Else: shift left, insert 0.
  - Counter increments. After the 32nd iteration (counter = 31 → 32), do the sign fix-up and go to END.
- **Sign fix-up** (signed only):
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend was negative.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (wraps; no trap).
- **annul_i** = 1 in ON or BYZERO: go to IDLE next edge, counter = 0, `result_o` = 0, `ready_o` stays 0.
- **END**:
  - `ready_o` = 1 and `result_o` holds the final value while `start_i` = 1.
  - When `start_i` = 0, go to IDLE; `ready_o` and `result_o` go to 0 on that edge.
  - `annul_i` in END is ignored; the result has already been committed to the handshake.
- Operands are latched at start. Input changes during ON do not affect the result.

## Timing
- Edge E0 samples `start_i` in IDLE.
- Nonzero divisor: E1..E32 perform the iterations; state = END after E32. `ready_o` rises after E32 (32-cycle latency) and `result_o` is registered.
- Zero divisor: BYZERO after E0, END after E1, so `ready_o` is high 2 edges after start.
- `ready_o` stays high until the first edge that sees `start_i` = 0, then drops.
- Back-to-back operation: `start_i` must go low for at least one cycle (END → IDLE) before the next request. A new start is accepted in IDLE on the following edge.
- Async `rst` asserted mid-ON: outputs go to 0 immediately, without waiting for a clock edge. On release the unit is in IDLE.
- All outputs are registered. There is no combinational path from the inputs to `ready_o` or `result_o`.

## Test plan
- **DIVU 100 / 7**: `start_i` held → `ready_o` after exactly 32 edges, `result_o` = 0x00000002_0000000E. Drop `start_i` → `ready_o` = 0 and `result_o` = 0 next edge.
- **DIV −7 / 2** (0xFFFFFFF9, 0x00000002) → `result_o` = 0xFFFFFFFF_FFFFFFFD. Also DIV 7 / −2 → 0x00000001_FFFFFFFD.
- **DIV 0x80000000 / 0xFFFFFFFF** → 0x00000000_80000000. Also DIVU 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
- **DIVU 5 / 0** → `ready_o` after 2 edges, `result_o` = 0.
- **Flush**: start DIVU 100 / 7, assert `annul_i` at iteration 10 → IDLE next edge, `ready_o` never rises. Then start 9 / 3 → 0x00000000_00000003 after 32 edges.
- **Reset**: assert `rst` asynchronously mid-ON (between edges) → `ready_o` = 0 and `result_o` = 0 immediately. Release, then run a new divide and check it is correct.

Source files
------------

// File: rtl/div_if.sv
// Handshake bundle between execute and the divider.
// Execute drives the request side; the divider returns result_o/ready_o.
interface div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
                    input  result_o, ready_o);
    modport slave  (input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
                    output result_o, ready_o);
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU, one quotient bit per cycle.
// result_o = {remainder, quotient}; all outputs registered.
module div_unit (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_e;

    state_e      state_q;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q;
    logic [5:0]  cnt_q;
    logic        neg_quot_q, neg_rem_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic [32:0] trial;
    logic        trial_neg;
    logic [31:0] abs1, abs2, quot_fix, rem_fix;

    always_comb begin
        abs1 = (bus.signed_div_i && bus.opdata1_i[31]) ? 32'(-bus.opdata1_i) : bus.opdata1_i;
        abs2 = (bus.signed_div_i && bus.opdata2_i[31]) ? 32'(-bus.opdata2_i) : bus.opdata2_i;
        trial = work_q[63:31] - {1'b0, divisor_q};
        // A set top bit would mean the partial remainder already exceeds any divisor.
        trial_neg = trial[32] & ~work_q[64];
        if (trial_neg)
            work_d = {work_q[63:0], 1'b0};
        else
            work_d = {1'b0, trial[31:0], work_q[30:0], 1'b1};
        quot_fix = neg_quot_q ? 32'(-work_d[31:0])  : work_d[31:0];
        rem_fix  = neg_rem_q  ? 32'(-work_d[63:32]) : work_d[63:32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            work_q     <= '0;
            divisor_q  <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q  <= 1'b0;
                    result_q <= '0;
                    if (bus.start_i && !bus.annul_i) begin
                        cnt_q <= '0;
                        if (bus.opdata2_i == 32'd0) begin
                            state_q <= S_BYZERO;
                        end else begin
                            state_q    <= S_ON;
                            work_q     <= {33'd0, abs1};
                            divisor_q  <= abs2;
                            neg_quot_q <= bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                            neg_rem_q  <= bus.signed_div_i & bus.opdata1_i[31];
                        end
                    end
                end
                S_BYZERO: begin
                    result_q <= '0;
                    if (bus.annul_i) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= S_END;
                        ready_q <= 1'b1;
                    end
                end
                S_ON: begin
                    if (bus.annul_i) begin
                        state_q  <= S_IDLE;
                        cnt_q    <= '0;
                        result_q <= '0;
                    end else begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            result_q <= {rem_fix, quot_fix};
                            ready_q  <= 1'b1;
                            state_q  <= S_END;
                        end
                    end
                end
                S_END: begin
                    // Flush is ignored here: the result is already handed to execute.
                    if (!bus.start_i) begin
                        state_q  <= S_IDLE;
                        ready_q  <= 1'b0;
                        result_q <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule
